// File: rtl/mem_ctrl_arbiter_pkg.sv
// rtl/mem_ctrl_arbiter_pkg.sv - State encoding, width codes and beat-count helper
package mem_ctrl_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } state_e;

  localparam logic [1:0] MemByte = 2'b00;
  localparam logic [1:0] MemHalf = 2'b01;
  localparam logic [1:0] MemWord = 2'b10;

  // Number of byte beats for a MEM width code; 11 is treated as a word.
  function automatic logic [2:0] beat_count(input logic [1:0] width);
    case (width)
      MemByte: beat_count = 3'd1;
      MemHalf: beat_count = 3'd2;
      default: beat_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arbiter_if.sv
// rtl/mem_ctrl_arbiter_if.sv - Requester and RAM-side signal bundle for the arbiter
interface mem_ctrl_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_inst;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_width;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic              stallreq_if;
  logic              stallreq_mem;

  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  // Master: the pipeline requesters plus the RAM that answers reads.
  modport master (
    output if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_addr, mem_width, mem_wdata,
    output ram_din,
    input  if_done, if_inst, mem_done, mem_rdata,
    input  stallreq_if, stallreq_mem,
    input  ram_a, ram_wr, ram_dout
  );

  // Slave: the arbiter itself.
  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_addr, mem_width, mem_wdata,
    input  ram_din,
    output if_done, if_inst, mem_done, mem_rdata,
    output stallreq_if, stallreq_mem,
    output ram_a, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_ctrl_arbiter.sv
// rtl/mem_ctrl_arbiter.sv - Byte-wide RAM port arbiter between instruction fetch and MEM stage
import mem_ctrl_arbiter_pkg::*;

module mem_ctrl_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  mem_ctrl_arbiter_if.slave io_bus
);

  state_e            r_state;
  logic [2:0]        r_cnt;
  logic [2:0]        r_n;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_data;
  logic [ADDR_W-1:0] r_ram_a;
  logic              r_ram_wr;
  logic [7:0]        r_ram_dout;
  logic              r_if_done;
  logic              r_mem_done;
  logic [31:0]       r_if_inst;
  logic [31:0]       r_mem_rdata;

  state_e            w_state_nxt;
  logic [2:0]        w_cnt_nxt;
  logic [2:0]        w_n_nxt;
  logic [ADDR_W-1:0] w_base_nxt;
  logic [31:0]       w_data_nxt;
  logic [ADDR_W-1:0] w_ram_a_nxt;
  logic              w_ram_wr_nxt;
  logic [7:0]        w_ram_dout_nxt;
  logic              w_if_done_nxt;
  logic              w_mem_done_nxt;
  logic [31:0]       w_if_inst_nxt;
  logic [31:0]       w_mem_rdata_nxt;
  logic [1:0]        w_byte_idx;
  logic [ADDR_W-1:0] w_beat_addr;
  logic              w_mem_go;
  logic              w_if_go;

  // A requester whose done pulse is showing this cycle is finished and must not be re-granted.
  assign w_mem_go = io_bus.mem_req & ~r_mem_done;
  assign w_if_go  = io_bus.if_req  & ~r_if_done;

  // Stall whenever a request is pending and its completion is not showing yet.
  assign io_bus.stallreq_if  = io_bus.if_req  & ~r_if_done;
  assign io_bus.stallreq_mem = io_bus.mem_req & ~r_mem_done;

  assign io_bus.ram_a     = r_ram_a;
  assign io_bus.ram_wr    = r_ram_wr;
  assign io_bus.ram_dout  = r_ram_dout;
  assign io_bus.if_done   = r_if_done;
  assign io_bus.if_inst   = r_if_inst;
  assign io_bus.mem_done  = r_mem_done;
  assign io_bus.mem_rdata = r_mem_rdata;

  // r_cnt counts edges since grant; read data for beat k arrives two edges after it was issued.
  assign w_byte_idx  = r_cnt[1:0] - 2'd2;
  assign w_beat_addr = r_base + ADDR_W'(r_cnt);

  // Next-state and next-output logic: grant in IDLE, then sequence byte beats.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_n_nxt         = r_n;
    w_base_nxt      = r_base;
    w_data_nxt      = r_data;
    w_ram_a_nxt     = r_ram_a;
    w_ram_wr_nxt    = 1'b0;
    w_ram_dout_nxt  = r_ram_dout;
    w_if_done_nxt   = 1'b0;
    w_mem_done_nxt  = 1'b0;
    w_if_inst_nxt   = r_if_inst;
    w_mem_rdata_nxt = r_mem_rdata;

    case (r_state)
      ST_IDLE: begin
        if (w_mem_go) begin
          w_base_nxt  = io_bus.mem_addr;
          w_n_nxt     = beat_count(io_bus.mem_width);
          w_cnt_nxt   = 3'd1;
          w_ram_a_nxt = io_bus.mem_addr;
          if (io_bus.mem_we) begin
            // Write data is kept in the assembly register and shifted down one byte per beat.
            w_state_nxt    = ST_MEM_WR;
            w_ram_wr_nxt   = 1'b1;
            w_ram_dout_nxt = io_bus.mem_wdata[7:0];
            w_data_nxt     = {8'h00, io_bus.mem_wdata[31:8]};
          end else begin
            w_state_nxt = ST_MEM_RD;
            w_data_nxt  = '0;
          end
        end else if (w_if_go) begin
          w_state_nxt = ST_IF_RD;
          w_base_nxt  = io_bus.if_addr;
          w_n_nxt     = 3'd4;
          w_cnt_nxt   = 3'd1;
          w_ram_a_nxt = io_bus.if_addr;
          w_data_nxt  = '0;
        end
      end

      ST_MEM_WR: begin
        w_cnt_nxt = r_cnt + 3'd1;
        if (r_cnt < r_n) begin
          w_ram_a_nxt    = w_beat_addr;
          w_ram_wr_nxt   = 1'b1;
          w_ram_dout_nxt = r_data[7:0];
          w_data_nxt     = {8'h00, r_data[31:8]};
        end else begin
          w_mem_done_nxt = 1'b1;
          w_state_nxt    = ST_IDLE;
        end
      end

      ST_IF_RD, ST_MEM_RD: begin
        if (r_state == ST_IF_RD && io_bus.if_flush) begin
          // Abandon the fetch; the partial word is discarded and if_inst keeps its old value.
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt < r_n) begin
            w_ram_a_nxt = w_beat_addr;
          end
          if (r_cnt >= 3'd2) begin
            w_data_nxt[{w_byte_idx, 3'b000} +: 8] = io_bus.ram_din;
          end
          if (r_cnt == r_n + 3'd1) begin
            w_state_nxt = ST_IDLE;
            if (r_state == ST_IF_RD) begin
              w_if_done_nxt = 1'b1;
              w_if_inst_nxt = w_data_nxt;
            end else begin
              w_mem_done_nxt  = 1'b1;
              w_mem_rdata_nxt = w_data_nxt;
            end
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears every output at once, aborting any beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_n         <= '0;
      r_base      <= '0;
      r_data      <= '0;
      r_ram_a     <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_inst   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_n         <= w_n_nxt;
      r_base      <= w_base_nxt;
      r_data      <= w_data_nxt;
      r_ram_a     <= w_ram_a_nxt;
      r_ram_wr    <= w_ram_wr_nxt;
      r_ram_dout  <= w_ram_dout_nxt;
      r_if_done   <= w_if_done_nxt;
      r_mem_done  <= w_mem_done_nxt;
      r_if_inst   <= w_if_inst_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// tb/tb_mem_ctrl_arbiter.sv - Self-checking bench: directed scenarios plus randomized traffic vs. a timeline model
module tb_mem_ctrl_arbiter;

  localparam int ADDR_W = 32;
  localparam int NPRE   = 14;
  localparam logic [31:0] PRE_A [NPRE] = '{
    32'h100, 32'h101, 32'h102, 32'h103, 32'h40, 32'h41,
    32'h200, 32'h201, 32'h202, 32'h203,
    32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2};
  localparam logic [7:0] PRE_D [NPRE] = '{
    8'h13, 8'h00, 8'h50, 8'h00, 8'h11, 8'h22,
    8'hEF, 8'hBE, 8'hAD, 8'hDE,
    8'hA1, 8'hB2, 8'hC3, 8'hD4};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_ctrl_arbiter #(.ADDR_W(ADDR_W)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- RAM environment: synchronous byte RAM ----------------
  logic [7:0] ram [logic [31:0]];
  logic [7:0] mm  [logic [31:0]];
  bit ram_loaded = 1'b0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction
  function automatic logic [7:0] mm_rd(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < NPRE; i++) ram[PRE_A[i]] = PRE_D[i];
      ram_loaded = 1'b1;
    end
    bus.ram_din <= ram_rd(bus.ram_a);
    if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
  end

  // ---------------- Behavioural model: timeline of the granted access ----------------
  int          cyc = 0;
  logic        m_busy;
  bit          m_is_if;
  bit          m_we;
  int          m_t0, m_n;
  logic [31:0] m_base, m_wdata;
  logic [31:0] e_ram_a, e_if_inst, e_mem_rdata;
  logic        e_ram_wr, e_if_done, e_mem_done;
  logic [7:0]  e_ram_dout;

  always @(posedge clk or negedge rst_n) begin : model
    int k;
    logic [31:0] r;
    logic pif, pmem;
    if (!rst_n) begin
      m_busy = 1'b0; e_ram_a = '0; e_ram_wr = 1'b0; e_ram_dout = '0;
      e_if_done = 1'b0; e_mem_done = 1'b0; e_if_inst = '0; e_mem_rdata = '0;
      if (mm.num() == 0) for (int i = 0; i < NPRE; i++) mm[PRE_A[i]] = PRE_D[i];
    end else begin
      cyc++;
      if (e_ram_wr) mm[e_ram_a] = e_ram_dout;
      pif = e_if_done; pmem = e_mem_done;
      e_if_done = 1'b0; e_mem_done = 1'b0; e_ram_wr = 1'b0;
      if (m_busy) begin
        k = cyc - m_t0;
        if (m_is_if && bus.if_flush) begin
          m_busy = 1'b0;
        end else if (m_we) begin
          if (k < m_n) begin
            e_ram_a = m_base + 32'(k); e_ram_wr = 1'b1; e_ram_dout = m_wdata[8*k +: 8];
          end else begin
            e_mem_done = 1'b1; m_busy = 1'b0;
          end
        end else begin
          if (k < m_n) e_ram_a = m_base + 32'(k);
          if (k == m_n + 1) begin
            r = '0;
            for (int b = 0; b < m_n; b++) r[8*b +: 8] = mm_rd(m_base + 32'(b));
            if (m_is_if) begin e_if_done = 1'b1; e_if_inst = r; end
            else begin e_mem_done = 1'b1; e_mem_rdata = r; end
            m_busy = 1'b0;
          end
        end
      end else if (bus.mem_req && !pmem) begin
        m_busy = 1'b1; m_is_if = 1'b0; m_we = bus.mem_we; m_t0 = cyc;
        m_base = bus.mem_addr; m_wdata = bus.mem_wdata;
        m_n = (bus.mem_width == 2'b00) ? 1 : (bus.mem_width == 2'b01) ? 2 : 4;
        e_ram_a = m_base;
        if (m_we) begin e_ram_wr = 1'b1; e_ram_dout = m_wdata[7:0]; end
      end else if (bus.if_req && !pif) begin
        m_busy = 1'b1; m_is_if = 1'b1; m_we = 1'b0; m_t0 = cyc;
        m_base = bus.if_addr; m_wdata = '0; m_n = 4;
        e_ram_a = m_base;
      end
    end
  end

  // ---------------- Checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("ram_a",        bus.ram_a,                e_ram_a);
    check("ram_wr",       32'(bus.ram_wr),          32'(e_ram_wr));
    check("ram_dout",     32'(bus.ram_dout),        32'(e_ram_dout));
    check("if_done",      32'(bus.if_done),         32'(e_if_done));
    check("if_inst",      bus.if_inst,              e_if_inst);
    check("mem_done",     32'(bus.mem_done),        32'(e_mem_done));
    check("mem_rdata",    bus.mem_rdata,            e_mem_rdata);
    check("stallreq_if",  32'(bus.stallreq_if),     32'(bus.if_req & ~e_if_done));
    check("stallreq_mem", 32'(bus.stallreq_mem),    32'(bus.mem_req & ~e_mem_done));
  endtask

  task automatic wait_done(input string name, input bit is_if, output int edge_at);
    bit ok = 1'b0;
    edge_at = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (is_if ? bus.if_done : bus.mem_done) begin ok = 1'b1; edge_at = cyc; end
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 7));
    return 32'($urandom_range(0, 63));
  endfunction

  task automatic rand_drive();
    bus.if_flush = 1'b0;
    if (!bus.if_req || bus.if_done) begin
      bus.if_req  = ($urandom_range(0, 2) == 0);
      bus.if_addr = rand_addr();
    end else if ($urandom_range(0, 19) == 0) begin
      bus.if_flush = 1'b1;
      bus.if_addr  = rand_addr();
    end
    if (!bus.mem_req || bus.mem_done) begin
      bus.mem_req   = ($urandom_range(0, 2) == 0);
      bus.mem_we    = ($urandom_range(0, 1) == 1);
      bus.mem_width = 2'($urandom_range(0, 3));
      bus.mem_addr  = rand_addr();
      bus.mem_wdata = $urandom();
    end
  endtask

  // ---------------- Directed scenarios then random traffic ----------------
  task automatic run_main();
    int g, e, g2, mdone, idone;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0;
    bus.mem_width = 2'b00; bus.mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ram_a", bus.ram_a, 32'h0);
    check("rst_ram_wr", 32'(bus.ram_wr), 32'h0);
    check("rst_if_done", 32'(bus.if_done), 32'h0);
    check("rst_mem_rdata", bus.mem_rdata, 32'h0);
    rst_n = 1'b1;

    // Word fetch
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h100; g = cyc + 1;
    wait_done("fetch", 1'b1, e);
    check("fetch_latency", 32'(e - g), 32'd5);
    check("fetch_inst", bus.if_inst, 32'h0050_0013);
    bus.if_req = 1'b0;

    // Byte store
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_width = 2'b00;
    bus.mem_addr = 32'h20; bus.mem_wdata = 32'hAABB_CCDD; g = cyc + 1;
    @(posedge clk); #1;
    check("bst_ram_a", bus.ram_a, 32'h20);
    check("bst_ram_wr", 32'(bus.ram_wr), 32'd1);
    check("bst_ram_dout", 32'(bus.ram_dout), 32'hDD);
    wait_done("bst", 1'b0, e);
    check("bst_latency", 32'(e - g), 32'd1);
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    @(negedge clk);
    check("bst_ram20", 32'(ram_rd(32'h20)), 32'hDD);
    check("bst_ram21", 32'(ram_rd(32'h21)), 32'h00);

    // Contention: MEM half load wins, IF follows without a dead cycle
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_width = 2'b01; bus.mem_addr = 32'h40;
    g = cyc + 1; mdone = -1; idone = -1;
    for (int i = 0; i < 40 && idone < 0; i++) begin
      @(negedge clk);
      if (bus.mem_done && mdone < 0) begin
        mdone = cyc;
        check("cont_rdata", bus.mem_rdata, 32'h0000_2211);
        bus.mem_req = 1'b0;
      end
      if (bus.if_done) idone = cyc;
      else check("cont_stall_if", 32'(bus.stallreq_if), 32'd1);
    end
    check("cont_mem_latency", 32'(mdone - g), 32'd3);
    check("cont_if_after_mem", 32'(idone - mdone), 32'd6);
    check("cont_inst", bus.if_inst, 32'h0050_0013);
    bus.if_req = 1'b0;

    // Flush after two IF beats
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    @(negedge clk); @(negedge clk);
    bus.if_flush = 1'b1; bus.if_addr = 32'h100;
    @(negedge clk);
    bus.if_flush = 1'b0; g2 = cyc + 1;
    check("flush_no_done", 32'(bus.if_done), 32'd0);
    check("flush_inst_kept", bus.if_inst, 32'h0050_0013);
    wait_done("flush_refetch", 1'b1, e);
    check("flush_refetch_latency", 32'(e - g2), 32'd5);
    check("flush_refetch_inst", bus.if_inst, 32'h0050_0013);
    bus.if_req = 1'b0;

    // Reset during beat 2 of a word store
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_width = 2'b10;
    bus.mem_addr = 32'h300; bus.mem_wdata = 32'h4433_2211;
    repeat (3) @(posedge clk);
    #3;
    check("rmw_beat2_wr", 32'(bus.ram_wr), 32'd1);
    check("rmw_beat2_a", bus.ram_a, 32'h302);
    rst_n = 1'b0;
    #1;
    check("rmw_ram_wr", 32'(bus.ram_wr), 32'd0);
    check("rmw_ram_a", bus.ram_a, 32'h0);
    check("rmw_ram_dout", 32'(bus.ram_dout), 32'h0);
    check("rmw_mem_done", 32'(bus.mem_done), 32'h0);
    check("rmw_if_inst", bus.if_inst, 32'h0);
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rmw_ram301", 32'(ram_rd(32'h301)), 32'h22);
    check("rmw_ram302", 32'(ram_rd(32'h302)), 32'h00);

    // Word read that wraps past the top of the address space
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_width = 2'b10; bus.mem_addr = 32'hFFFF_FFFF; g = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("wrap_a%0d", k), bus.ram_a, 32'hFFFF_FFFF + 32'(k));
    end
    wait_done("wrap", 1'b0, e);
    check("wrap_latency", 32'(e - g), 32'd5);
    check("wrap_rdata", bus.mem_rdata, 32'hD4C3_B2A1);
    bus.mem_req = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rand_drive();
    end
    @(negedge clk);
    bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.if_flush = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    bus.ram_din = 8'h00;
    fork
      begin : cmp
        forever begin
          @(posedge clk); #1;
          if (rst_n) compare_all();
        end
      end
      begin : seq
        run_main();
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
